// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline hazard status in, stage enables/flushes/counters out
`timescale 1ns/1ps
interface hazard_unit_if #(parameter int CNT_W = 16);
    logic             ihit;
    logic             dhit;
    logic             dREN_mem;
    logic             dWEN_mem;
    logic             memread_ex;
    logic [4:0]       wsel_ex;
    logic [4:0]       rsel1_id;
    logic [4:0]       rsel2_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             jump_id;
    logic             brtaken_mem;
    logic             halt_wb;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        output ihit, dhit, dREN_mem, dWEN_mem, memread_ex, wsel_ex, rsel1_id, rsel2_id,
               use_rs_id, use_rt_id, jump_id, brtaken_mem, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halted, stall_cnt, squash_cnt
    );

    modport slave (
        input  ihit, dhit, dREN_mem, dWEN_mem, memread_ex, wsel_ex, rsel1_id, rsel2_id,
               use_rs_id, use_rt_id, jump_id, brtaken_mem, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halted, stall_cnt, squash_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush control for the five-stage pipeline
`timescale 1ns/1ps
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    hazard_unit_if.slave  hif
);
    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;
    typedef enum logic [2:0] {
        R_HALT, R_FREEZE, R_BRANCH, R_JUMP, R_SQUASH, R_LU, R_IMISS, R_RUN
    } rule_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    rule_t            rule;
    logic             squash_pend, squash_pend_nxt;
    logic [CNT_W-1:0] stall_cnt_q, squash_cnt_q;
    logic [CNT_W:0]   squash_sum;
    logic [1:0]       squash_add;
    logic             lu, dmiss;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign lu = hif.memread_ex && (hif.wsel_ex != 5'd0) &&
                ((hif.use_rs_id && (hif.rsel1_id == hif.wsel_ex)) ||
                 (hif.use_rt_id && (hif.rsel2_id == hif.wsel_ex)));
    assign dmiss = (hif.dREN_mem || hif.dWEN_mem) && !hif.dhit;

    // A pending squash only fires once the wrong-path word actually lands (ihit).
    always_comb begin
        rule = R_RUN;
        if (state == HALT || hif.halt_wb)     rule = R_HALT;
        else if (dmiss)                       rule = R_FREEZE;
        else if (hif.brtaken_mem)             rule = R_BRANCH;
        else if (hif.jump_id)                 rule = R_JUMP;
        else if (squash_pend && hif.ihit)     rule = R_SQUASH;
        else if (lu)                          rule = R_LU;
        else if (!hif.ihit)                   rule = R_IMISS;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= RUN;
            squash_pend  <= 1'b0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            state       <= state_nxt;
            squash_pend <= squash_pend_nxt;
            if (state != HALT && !pc_en && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            squash_cnt_q <= squash_sum[CNT_W] ? CNT_MAX : squash_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (dmiss)    state_nxt = DWAIT;
            DWAIT:   if (hif.dhit) state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
        if (hif.halt_wb)
            state_nxt = HALT;

        squash_pend_nxt = squash_pend;
        case (rule)
            R_BRANCH, R_JUMP: squash_pend_nxt = !hif.ihit;
            R_SQUASH:         squash_pend_nxt = 1'b0;
            default:          squash_pend_nxt = squash_pend;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        squash_add  = 2'd0;
        if (!nRST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en}         = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush}    = 4'b1111;
        end else begin
            case (rule)
                R_HALT: {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                R_FREEZE: begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_flush = 1'b1;
                end
                R_BRANCH: begin
                    {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                    squash_add = 2'd3;
                end
                R_JUMP, R_SQUASH: begin
                    ifid_flush = 1'b1;
                    squash_add = 2'd1;
                end
                R_LU: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                R_IMISS: begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
        squash_sum = {1'b0, squash_cnt_q} + (CNT_W+1)'(squash_add);
    end

    assign hif.pc_en       = pc_en;
    assign hif.ifid_en     = ifid_en;
    assign hif.idex_en     = idex_en;
    assign hif.exmem_en    = exmem_en;
    assign hif.memwb_en    = memwb_en;
    assign hif.ifid_flush  = ifid_flush;
    assign hif.idex_flush  = idex_flush;
    assign hif.exmem_flush = exmem_flush;
    assign hif.memwb_flush = memwb_flush;
    assign hif.halted      = (state == HALT);
    assign hif.stall_cnt   = stall_cnt_q;
    assign hif.squash_cnt  = squash_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed and randomized checks of hazard_unit against a rule model
`timescale 1ns/1ps
module tb_hazard_unit;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_unit_if #(.CNT_W(16)) hif();
    hazard_unit #(.CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .hif(hif));

    always #5 CLK = ~CLK;

    logic [8:0] dut_v;
    assign dut_v = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                    hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush};

    localparam int R_HALT = 0, R_FREEZE = 1, R_BRANCH = 2, R_JUMP = 3, R_SQUASH = 4,
                   R_LU = 5, R_IMISS = 6, R_RUN = 7;
    localparam int CMAX = 65535;

    int m_stall, m_squash;
    bit m_halted, m_pend;

    function automatic int m_rule();
        bit reads_load;
        reads_load = hif.memread_ex && hif.wsel_ex != 0 &&
                     ((hif.use_rs_id && hif.rsel1_id == hif.wsel_ex) ||
                      (hif.use_rt_id && hif.rsel2_id == hif.wsel_ex));
        if (m_halted || hif.halt_wb) return R_HALT;
        if ((hif.dREN_mem || hif.dWEN_mem) && !hif.dhit) return R_FREEZE;
        if (hif.brtaken_mem) return R_BRANCH;
        if (hif.jump_id) return R_JUMP;
        if (m_pend && hif.ihit) return R_SQUASH;
        if (reads_load) return R_LU;
        if (!hif.ihit) return R_IMISS;
        return R_RUN;
    endfunction

    function automatic logic [8:0] m_out();
        if (!nRST) return 9'b00000_1111;
        case (m_rule())
            R_HALT:   return 9'b00000_0000;
            R_FREEZE: return 9'b00001_0001;
            R_BRANCH: return 9'b11111_1110;
            R_JUMP:   return 9'b11111_1000;
            R_SQUASH: return 9'b11111_1000;
            R_LU:     return 9'b00111_0100;
            R_IMISS:  return 9'b01111_1000;
            default:  return 9'b11111_0000;
        endcase
    endfunction

    task automatic tick();
        int r;
        int add;
        logic [8:0] e;
        r = m_rule();
        e = m_out();
        if (!m_halted && !e[8]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        add = (r == R_BRANCH) ? 3 : ((r == R_JUMP || r == R_SQUASH) ? 1 : 0);
        m_squash = (m_squash + add > CMAX) ? CMAX : m_squash + add;
        if (r == R_BRANCH || r == R_JUMP) m_pend = !hif.ihit;
        else if (r == R_SQUASH) m_pend = 1'b0;
        if (hif.halt_wb) m_halted = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        hif.ihit = 1'b1; hif.dhit = 1'b0; hif.dREN_mem = 1'b0; hif.dWEN_mem = 1'b0;
        hif.memread_ex = 1'b0; hif.wsel_ex = 5'd0; hif.rsel1_id = 5'd0; hif.rsel2_id = 5'd0;
        hif.use_rs_id = 1'b0; hif.use_rt_id = 1'b0; hif.jump_id = 1'b0;
        hif.brtaken_mem = 1'b0; hif.halt_wb = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        m_stall = 0; m_squash = 0; m_halted = 1'b0; m_pend = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        #2;
        n_tests++;
        if (dut_v !== 9'b00000_1111) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=%b", dut_v, 9'b00000_1111);
        end
        n_tests++;
        if (hif.halted !== 1'b0 || hif.stall_cnt !== 16'd0 || hif.squash_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_state halted=%b stall=%0d squash=%0d exp 0/0/0",
                               hif.halted, hif.stall_cnt, hif.squash_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        hif.memread_ex = 1'b1; hif.wsel_ex = 5'd5; hif.rsel1_id = 5'd5; hif.use_rs_id = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 9'b00111_0100) begin
            n_fail++; $display("FAIL load_use_bubble got=%b exp=%b", dut_v, 9'b00111_0100);
        end
        tick();
        hif.memread_ex = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000 || hif.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL load_use_release got=%b stall=%0d exp=%b stall=1",
                               dut_v, hif.stall_cnt, 9'b11111_0000);
        end
        hif.memread_ex = 1'b1; hif.wsel_ex = 5'd0; hif.rsel1_id = 5'd0;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000) begin
            n_fail++; $display("FAIL load_r0_no_stall got=%b exp=%b", dut_v, 9'b11111_0000);
        end
        hif.wsel_ex = 5'd5; hif.use_rs_id = 1'b0; hif.rsel2_id = 5'd5; hif.use_rt_id = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000) begin
            n_fail++; $display("FAIL load_rt_unused_no_stall got=%b exp=%b", dut_v, 9'b11111_0000);
        end
    endtask

    task automatic test_dmiss();
        do_reset();
        hif.dREN_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (dut_v !== 9'b00001_0001) begin
                n_fail++; $display("FAIL dmiss_freeze cycle=%0d got=%b exp=%b", i, dut_v, 9'b00001_0001);
            end
            tick();
        end
        hif.dhit = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000 || hif.stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL dmiss_advance got=%b stall=%0d exp=%b stall=3",
                               dut_v, hif.stall_cnt, 9'b11111_0000);
        end
    endtask

    task automatic test_branch_squash();
        do_reset();
        hif.brtaken_mem = 1'b1; hif.ihit = 1'b0; hif.jump_id = 1'b1;
        hif.memread_ex = 1'b1; hif.wsel_ex = 5'd3; hif.rsel1_id = 5'd3; hif.use_rs_id = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_1110) begin
            n_fail++; $display("FAIL branch_flush got=%b exp=%b", dut_v, 9'b11111_1110);
        end
        tick();
        idle_inputs();
        hif.ihit = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 9'b01111_1000) begin
            n_fail++; $display("FAIL branch_wait_ihit got=%b exp=%b", dut_v, 9'b01111_1000);
        end
        tick();
        hif.ihit = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_1000) begin
            n_fail++; $display("FAIL squash_pend_flush got=%b exp=%b", dut_v, 9'b11111_1000);
        end
        tick();
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000 || hif.squash_cnt !== 16'd4 || hif.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL squash_count got=%b squash=%0d stall=%0d exp=%b squash=4 stall=1",
                               dut_v, hif.squash_cnt, hif.stall_cnt, 9'b11111_0000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hif.dREN_mem = 1'b1;
        tick();
        tick();
        #2;
        nRST = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 9'b00000_1111 || hif.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_in_dwait got=%b stall=%0d exp=%b stall=0",
                               dut_v, hif.stall_cnt, 9'b00000_1111);
        end
        do_reset();
        hif.brtaken_mem = 1'b1; hif.ihit = 1'b0;
        tick();
        #2;
        nRST = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 9'b00000_1111 || hif.squash_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_with_pend got=%b squash=%0d exp=%b squash=0",
                               dut_v, hif.squash_cnt, 9'b00000_1111);
        end
        do_reset();
        #1;
        n_tests++;
        if (dut_v !== 9'b11111_0000 || hif.halted !== 1'b0) begin
            n_fail++; $display("FAIL no_stale_squash got=%b halted=%b exp=%b halted=0",
                               dut_v, hif.halted, 9'b11111_0000);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            hif.ihit        = ($urandom_range(3) != 0);
            hif.dhit        = $urandom_range(1);
            hif.dREN_mem    = ($urandom_range(4) == 0);
            hif.dWEN_mem    = ($urandom_range(6) == 0);
            hif.memread_ex  = ($urandom_range(2) == 0);
            hif.wsel_ex     = 5'($urandom_range(3));
            hif.rsel1_id    = 5'($urandom_range(3));
            hif.rsel2_id    = 5'($urandom_range(3));
            hif.use_rs_id   = $urandom_range(1);
            hif.use_rt_id   = $urandom_range(1);
            hif.jump_id     = ($urandom_range(7) == 0);
            hif.brtaken_mem = ($urandom_range(7) == 0);
            hif.halt_wb     = 1'b0;
            #1;
            n_tests++;
            if (dut_v !== m_out()) begin
                n_fail++; $display("FAIL random_ctrl cycle=%0d got=%b exp=%b", i, dut_v, m_out());
            end
            n_tests++;
            if (hif.stall_cnt !== 16'(m_stall) || hif.squash_cnt !== 16'(m_squash) ||
                hif.halted !== m_halted) begin
                n_fail++; $display("FAIL random_state cycle=%0d stall=%0d/%0d squash=%0d/%0d halted=%b/%b",
                                   i, hif.stall_cnt, m_stall, hif.squash_cnt, m_squash,
                                   hif.halted, m_halted);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        do_reset();
        hif.halt_wb = 1'b1; hif.brtaken_mem = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 9'b00000_0000 || hif.halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_same_cycle got=%b halted=%b exp=%b halted=0",
                               dut_v, hif.halted, 9'b00000_0000);
        end
        tick();
        hif.halt_wb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hif.brtaken_mem = (i % 2 == 0);
            hif.dREN_mem    = (i % 2 == 1);
            #1;
            n_tests++;
            if (dut_v !== 9'b00000_0000 || hif.halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_sticky cycle=%0d got=%b halted=%b exp=%b halted=1",
                                   i, dut_v, hif.halted, 9'b00000_0000);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hif.dREN_mem = 1'b1;
        for (int i = 0; i < 65541; i++) @(posedge CLK);
        #1;
        n_tests++;
        if (hif.stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_saturate got=%h exp=%h", hif.stall_cnt, 16'hFFFF);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss();
        test_branch_squash();
        test_reset_mid();
        test_random();
        test_halt();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
